// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the round-robin APB master arbiter.
// Holds the sequencer state encoding and the timeout-counter width helper.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [31:0] APB_ERR_DATA = 32'hdeadbeef;

  // Width of a counter that must reach TIMEOUT-1; never narrower than one bit.
  function automatic int to_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1,
// wrapping modulo M.
module rr_pick #(
  parameter int M  = 2,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= M; k++) begin
      if (!valid && req[(int'(last) + k) % M]) begin
        valid = 1'b1;
        idx   = IW'((int'(last) + k) % M);
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB master port among M req/ack requesters with round-robin
// arbitration and a bounded ACCESS-phase wait.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int M       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [M-1:0]    req_vec,
  input  logic [M-1:0]    req_write,
  input  logic [M*32-1:0] req_addr,
  input  logic [M*32-1:0] req_wdata,
  output logic [M-1:0]  ack_vec,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          m_psel,
  output logic          m_penable,
  output logic          m_pwrite,
  output logic [31:0]   m_paddr,
  output logic [31:0]   m_pwdata,
  input  logic          m_pready,
  input  logic [31:0]   m_prdata
);

  localparam int IW   = (M > 1) ? $clog2(M) : 1;
  localparam int TO_W = to_w(TIMEOUT);

  state_t          state, state_nxt;
  logic [IW-1:0]   grant, last_grant;
  logic [TO_W-1:0] count;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            timed_out;

  rr_pick #(.M(M), .IW(IW)) u_pick (
    .req   (req_vec),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign timed_out = (TIMEOUT != 0) && (count == TO_W'(TIMEOUT - 1));

  // Bus controls decode straight from the state register, so an async reset
  // drops psel/penable/ack in the same instant.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    ack_vec   = '0;
    case (state)
      IDLE:   if (pick_valid) state_nxt = SETUP;
      SETUP: begin
        m_psel    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        if (m_pready || timed_out) state_nxt = DONE;
      end
      DONE: begin
        ack_vec[grant] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(M - 1);
      count      <= '0;
      m_pwrite   <= 1'b0;
      m_paddr    <= '0;
      m_pwdata   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= pick_idx;
            m_pwrite <= req_write[pick_idx];
            m_paddr  <= req_addr[pick_idx*32 +: 32];
            m_pwdata <= req_wdata[pick_idx*32 +: 32];
            count    <= '0;
          end
        end
        ACCESS: begin
          if (m_pready) begin
            rsp_rdata <= m_prdata;
            rsp_err   <= 1'b0;
          end else if (timed_out) begin
            rsp_rdata <= APB_ERR_DATA;
            rsp_err   <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE:    last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_apb_master_arb;

  localparam int M       = 2;
  localparam int TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [M-1:0]    req_vec = '0;
  logic [M-1:0]    req_write = '0;
  logic [M*32-1:0] req_addr = '0;
  logic [M*32-1:0] req_wdata = '0;
  logic [M-1:0]    ack_vec;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            m_psel, m_penable, m_pwrite;
  logic [31:0]     m_paddr, m_pwdata;
  logic            m_pready = 1'b0;
  logic [31:0]     m_prdata = '0;

  apb_master_arb #(.M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_vec   (req_vec),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack_vec   (ack_vec),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_pready  (m_pready),
    .m_prdata  (m_prdata)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending requests per requester plus the last winner.
  bit          pend [M];
  logic        pw   [M];
  logic [31:0] pa   [M];
  logic [31:0] pd   [M];
  int          last = M - 1;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  int          prev_ack = 0;
  bit          keep_busy = 1'b0;

  task automatic raise_fixed(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    pend[i] = 1'b1;
    pw[i]   = w;
    pa[i]   = a;
    pd[i]   = d;
    req_vec[i]           = 1'b1;
    req_write[i]         = w;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic raise(input int i);
    raise_fixed(i, 1'($urandom & 1), $urandom, $urandom);
  endtask

  // Winner = pending requester with the smallest cyclic distance past last.
  function automatic int rr_winner();
    int best = -1;
    int best_d = M + 1;
    for (int i = 0; i < M; i++) begin
      int d;
      d = (i - last - 1 + 2 * M) % M;
      if (pend[i] && d < best_d) begin
        best   = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < M; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Entered at the falling edge of an IDLE cycle whose next rising edge
  // arbitrates; returns at the same point of the following IDLE cycle.
  task automatic do_transfer(input int w, input bit rst_mid, input int exp_gap, input logic [31:0] rd);
    int win, acc;
    bit to;
    check("idle_psel", m_psel, 0);
    check("idle_ack", ack_vec, 0);
    win = rr_winner();
    if (win < 0) begin
      check("no_pending", 0, 1);
      return;
    end
    to  = (TIMEOUT != 0) && (w >= TIMEOUT);
    acc = to ? TIMEOUT : w + 1;

    @(negedge clk);
    check("setup_psel", m_psel, 1);
    check("setup_penable", m_penable, 0);
    check("setup_paddr", m_paddr, pa[win]);
    check("setup_pwrite", m_pwrite, pw[win]);
    check("setup_pwdata", m_pwdata, pd[win]);
    check("hold_rdata", rsp_rdata, exp_rdata);
    check("hold_err", rsp_err, exp_err);
    m_pready = 1'b0;
    m_prdata = $urandom;

    for (int k = 0; k < acc; k++) begin
      @(negedge clk);
      check("access_psel", m_psel, 1);
      check("access_penable", m_penable, 1);
      check("access_paddr", m_paddr, pa[win]);
      check("access_ack", ack_vec, 0);
      if (rst_mid && k == 1) begin
        rstn = 1'b0;
        #1;
        check("rst_psel", m_psel, 0);
        check("rst_penable", m_penable, 0);
        check("rst_ack", ack_vec, 0);
        check("rst_paddr", m_paddr, 0);
        check("rst_rdata", rsp_rdata, 0);
        exp_rdata = '0;
        exp_err   = 1'b0;
        last      = M - 1;
        m_pready  = 1'b0;
        @(negedge clk);
        check("rst_hold_ack", ack_vec, 0);
        check("rst_hold_psel", m_psel, 0);
        rstn = 1'b1;
        return;
      end
      m_pready = (k == w);
      m_prdata = (k == w) ? rd : $urandom;
    end

    @(negedge clk);
    exp_rdata = to ? 32'hdeadbeef : rd;
    exp_err   = to;
    check("done_ack", ack_vec, 32'(1) << win);
    check("done_rdata", rsp_rdata, exp_rdata);
    check("done_err", rsp_err, exp_err);
    check("done_psel", m_psel, 0);
    check("done_penable", m_penable, 0);
    if (exp_gap > 0) check("ack_gap", cycle - prev_ack, exp_gap);
    prev_ack = cycle;
    pend[win]    = 1'b0;
    req_vec[win] = 1'b0;
    last         = win;
    m_pready     = 1'($urandom & 1);
    if (keep_busy) raise(win);

    @(negedge clk);
    m_pready = 1'b0;
    check("after_ack", ack_vec, 0);
  endtask

  initial begin
    for (int i = 0; i < M; i++) pend[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_psel0", m_psel, 0);
    check("rst_penable0", m_penable, 0);
    check("rst_pwrite0", m_pwrite, 0);
    check("rst_paddr0", m_paddr, 0);
    check("rst_pwdata0", m_pwdata, 0);
    check("rst_ack0", ack_vec, 0);
    check("rst_rdata0", rsp_rdata, 0);
    check("rst_err0", rsp_err, 0);
    rstn = 1'b1;

    // Zero-wait write from requester 0.
    raise_fixed(0, 1'b1, 32'h0001_0004, 32'ha5a5_0001);
    do_transfer(0, 1'b0, 0, 32'h0);

    // Read from requester 1 with three wait states.
    raise_fixed(1, 1'b0, 32'h0002_0000, 32'h0);
    do_transfer(3, 1'b0, 0, 32'h1234_5678);

    // Both requesting continuously: alternating grants, 4 cycles apart.
    keep_busy = 1'b1;
    raise(0);
    raise(1);
    do_transfer(0, 1'b0, 0, $urandom);
    for (int n = 0; n < 3; n++) do_transfer(0, 1'b0, 4, $urandom);
    keep_busy = 1'b0;

    // Slave never ready: timeout completion with error data.
    do_transfer(9, 1'b0, 0, $urandom);

    // Reset during ACCESS, then requester 0 regranted from IDLE.
    if (!pend[0]) raise(0);
    do_transfer(3, 1'b1, 0, $urandom);
    do_transfer(0, 1'b0, 0, $urandom);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < M; i++)
        if (!pend[i] && ($urandom % 3 == 0)) raise(i);
      if (!any_pending()) begin
        check("idle_nopend", m_psel, 0);
        @(negedge clk);
      end else begin
        do_transfer(int'($urandom_range(0, 6)), 1'b0, 0, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
